// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-while-requested grants and registered outputs.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD must be in 1..255");
   end

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_ptr, w_ptr_nxt;
   logic [2:0] r_idx, w_idx_nxt;
   logic [7:0] r_grant, w_grant_nxt;
   logic       r_valid, w_valid_nxt;

   logic [7:0] w_cand;
   logic       w_found;
   logic [2:0] w_win;
   logic       w_hold;
   logic       w_release;
   logic       w_force;

   // Rotate the candidates so ptr lands on bit 0, take the lowest set bit,
   // then rotate the offset back; the 3-bit add wraps mod 8.
   function automatic logic [2:0] pick_first(input logic [7:0] cand, input logic [2:0] ptr);
      logic [15:0] dbl;
      logic [2:0]  off;
      dbl = {cand, cand} >> ptr;
      off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (dbl[k]) off = 3'(k);
      end
      return ptr + off;
   endfunction

   // The outgoing owner is masked so a drop/re-raise in the same cycle cannot re-win.
   assign w_cand  = (r_state == ST_GRANT) ? (req & ~r_grant) : req;
   assign w_found = |w_cand;
   assign w_win   = pick_first(w_cand, r_ptr);

`ifdef ARB_TIMEOUT_EN
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_timeout;

   assign w_force = (r_state == ST_GRANT) && req[r_idx] && (r_cnt == 8'(MAX_HOLD - 1));
`else
   assign w_force = 1'b0;
`endif

   assign w_hold    = (r_state == ST_GRANT) && req[r_idx] && !w_force;
   assign w_release = (r_state == ST_GRANT) && !w_hold;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_grant_nxt = r_grant;
      w_valid_nxt = r_valid;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
      if (w_hold && r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;
`endif
      if (((r_state == ST_IDLE) || w_release) && w_found) begin
         w_state_nxt = ST_GRANT;
         w_idx_nxt   = w_win;
         w_grant_nxt = 8'b1 << w_win;
         w_valid_nxt = 1'b1;
         w_ptr_nxt   = w_win + 3'd1;
`ifdef ARB_TIMEOUT_EN
         w_cnt_nxt   = 8'd0;
`endif
      end else if (w_release) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = 3'd0;
         w_grant_nxt = 8'h00;
         w_valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
         w_cnt_nxt   = 8'd0;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= 3'd0;
         r_idx   <= 3'd0;
         r_grant <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_grant <= w_grant_nxt;
         r_valid <= w_valid_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_force;
      end
   end

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = r_valid;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-way round-robin arbiter sharing one resource slot (e.g. the register-file write port) between up to eight requesters.
- Selects one requester and holds the grant while that requester keeps its request asserted.
- Publishes the winner both as a 3-bit index and as a one-hot 8-bit grant, i.e. the decoded form of the index, so it can drive the write-enable decode directly.
- Sits between the requesting units and the shared write port.

Parameters:
- MAX_HOLD, 16: cycles an owner may hold the grant before forced release (used only with ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- req  input  8  request vector; bit i high = requester i wants, or is still using, the resource.
- grant  output  8  one-hot grant; all-zero when grant_valid=0.
- grant_idx  output  3  binary index of the current owner; 0 when grant_valid=0.
- grant_valid  output  1  high while some requester owns the resource.
- timeout  output  1  one-cycle pulse when an owner is forcibly released (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, grant=8'h00, grant_idx=0, grant_valid=0, timeout=0, rotation pointer ptr=0, hold counter=0.
  - Reset takes priority over all other events, including mid-grant; the owner loses the grant on the next edge.
- All outputs are registered; there are no combinational paths from req to outputs.
- Selection function: first i, scanning ptr, ptr+1, ... ptr+7 (mod 8), with the candidate vector's bit i set.
- IDLE:
  - If req != 0, at the edge: pick the winner from req; grant_idx=winner, grant=1<<winner, grant_valid=1, ptr=(winner+1) mod 8, counter=0; go to GRANT.
  - Latency is one cycle from req sampled to grant visible.
  - If req == 0, stay in IDLE with outputs 0.
- GRANT, owner o:
  - req[o]=1: hold all outputs; counter increments, saturating at 255.
  - req[o]=0: the owner releases. At the same edge, re-arbitrate over req with bit o masked off. If there is a winner, switch directly (back-to-back, no idle cycle) and stay in GRANT. Otherwise go to IDLE with grant_valid=0 and grant=0.
  - ptr only advances when a grant is issued.
- Fairness:
  - Pointer wrap: after owner 7, ptr=0.
  - A requester waiting with req held is granted within at most 7 ownership periods.
- Simultaneous events:
  - Multiple new requests: resolved by pointer order only.
  - A request from o re-asserted in the same cycle it is dropped is not seen, because o is masked for that edge.
- Invariants:
  - grant == (grant_valid ? 1<<grant_idx : 0) at every cycle.
  - grant is never multi-hot.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In GRANT, when counter reaches MAX_HOLD-1 with req[o] still high, the next edge force-releases o.
  - Re-arbitration masks o exactly as for a normal release.
  - timeout pulses high for that one cycle.
  - The owner must re-win arbitration later.
- ARB_TIMEOUT_EN not defined:
  - No counter logic; ownership is unbounded; timeout is constant 0.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with req=8'hFF → grant=0, grant_idx=0, grant_valid=0. Release reset → one edge later grant=8'h01, grant_idx=0.
- Single requester: req=8'h20 at edge N → at N+1 grant=8'h20, grant_idx=5, valid=1. Drop req at edge N+4 → at N+5 valid=0, grant=0.
- Back-to-back rotation: req=8'h89 held, owners drop req one cycle after grant then re-raise → grants cycle 0→3→7→0, each switch with no idle gap, one-hot every cycle.
- Pointer wrap/fairness: owner 7 released with req=8'h81 → next grant is 0 (ptr=0), not 7. Then owner 0 releases with req=8'h81 → grant 7.
- Reset mid-grant: owner 4 holding, assert reset_n=0 for one edge → all outputs 0 next cycle. After release with req=8'h10 → grant=8'h10 one cycle later, ptr restarted from 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=8'h06 held constantly → owner 1 for 4 cycles, timeout pulse, grant 2 for 4 cycles, timeout pulse, grant 1 again. Without the macro: owner 1 indefinitely, timeout=0.
